convolution_core: RTL and testbench

Datapath engine of the convolution IP. It sits directly downstream of the AIP host interface's input memories. When the AIP `start` strobe arrives, it reads sequence X and sequence Y from the two input memories. It computes the full linear convolution z[n] = Σ x[k]·y[n−k] and writes the result into the output memory, which the host later reads back through MDATAOUT. It reports `busy` and `done`; `done` drives the wrapper's interrupt Done flag (bit 0).

---
 rtl/convolution_core_if.sv | 38 +++
 rtl/convolution_core.sv | 205 ++++++++++++++++++++
 tb/tb_convolution_core.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/convolution_core_if.sv
// +----------------------------------------------------------------------------+
// | Module   : convolution_core_if                                             |
// | Purpose  : Memory-side bus of the convolution datapath. Bundles the X and  |
// |            Y read ports (synchronous read, 1-cycle latency) and the Z      |
// |            write port.                                                     |
// | Modports : master - convolution core (drives addresses / write strobe)     |
// |            slave  - memory side (returns read data)                        |
// | Signals  : x_addr/x_data, y_addr/y_data, z_addr/z_data/z_we                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface convolution_core_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRW_X   = 5,
  parameter int ADDRW_Y   = 5,
  parameter int ADDRW_Z   = 6
);
  logic [ADDRW_X-1:0]   x_addr;
  logic [DATAWIDTH-1:0] x_data;
  logic [ADDRW_Y-1:0]   y_addr;
  logic [DATAWIDTH-1:0] y_data;
  logic [ADDRW_Z-1:0]   z_addr;
  logic [DATAWIDTH-1:0] z_data;
  logic                 z_we;

  modport master (
    output x_addr, y_addr, z_addr, z_data, z_we,
    input  x_data, y_data
  );

  modport slave (
    input  x_addr, y_addr, z_addr, z_data, z_we,
    output x_data, y_data
  );
endinterface

`default_nettype wire

// File: rtl/convolution_core.sv
// +----------------------------------------------------------------------------+
// | Module   : convolution_core                                                |
// | Purpose  : Full linear convolution z[n] = sum x[k]*y[n-k] of two unsigned  |
// |            sequences read from the X/Y memories, written to Z memory.      |
// | Ports    : clk, rst (sync, active-high), en_s (global hold), start,        |
// |            size_x/size_y (lengths, sampled on accepted start),             |
// |            busy, done (one-cycle pulse), mem (convolution_core_if.master)  |
// | Config   : CONV_SATURATE_EN - saturate each result to all-ones when the    |
// |            accumulator exceeds DATAWIDTH bits (default: truncate).         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module convolution_core #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRW_X   = 5,
  parameter int ADDRW_Y   = 5,
  parameter int ADDRW_Z   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_s,
  input  logic               start,
  input  logic [ADDRW_X:0]   size_x,
  input  logic [ADDRW_Y:0]   size_y,
  output logic               busy,
  output logic               done,
  convolution_core_if.master mem
);

  // Index arithmetic is done in CW bits, wide enough for n, k and Nz.
  localparam int CW = ADDRW_Z + 1;
  localparam int AW = 2 * DATAWIDTH;
  localparam logic [ADDRW_X:0] MAX_X = {1'b1, {ADDRW_X{1'b0}}};
  localparam logic [ADDRW_Y:0] MAX_Y = {1'b1, {ADDRW_Y{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ADDRW_X:0]     nx_q, nx_d;
  logic [ADDRW_Y:0]     ny_q, ny_d;
  logic [CW-1:0]        n_q, n_d;
  logic [CW-1:0]        k_q, k_d;
  logic [CW-1:0]        kmax_q, kmax_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [ADDRW_X-1:0]   x_addr_q, x_addr_d;
  logic [ADDRW_Y-1:0]   y_addr_q, y_addr_d;
  logic [ADDRW_Z-1:0]   z_addr_q, z_addr_d;
  logic [DATAWIDTH-1:0] z_data_q, z_data_d;
  logic                 z_we_q, z_we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CW-1:0]        nx_w, ny_w, nlast_w, kmin_w, kmax_w;
  logic [AW-1:0]        prod_w, acc_sum_w;
  logic [DATAWIDTH-1:0] res_w;

  assign nx_w    = CW'(nx_q);
  assign ny_w    = CW'(ny_q);
  // Last output index Nz-1 = Nx+Ny-2; both lengths are >= 1 once latched.
  assign nlast_w = nx_w + ny_w - CW'(2);
  assign kmin_w  = (n_q >= ny_w - CW'(1)) ? (n_q - (ny_w - CW'(1))) : '0;
  assign kmax_w  = (n_q < nx_w - CW'(1)) ? n_q : (nx_w - CW'(1));

  // Read data arrives in MAC, one cycle after the address was presented in READ.
  assign prod_w    = AW'(mem.x_data) * AW'(mem.y_data);
  assign acc_sum_w = acc_q + prod_w;

`ifdef CONV_SATURATE_EN
  assign res_w = (|acc_sum_w[AW-1:DATAWIDTH]) ? '1 : acc_sum_w[DATAWIDTH-1:0];
`else
  assign res_w = acc_sum_w[DATAWIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    n_d      = n_q;
    k_d      = k_q;
    kmax_d   = kmax_q;
    acc_d    = acc_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;
    z_addr_d = z_addr_q;
    z_data_d = z_data_q;
    z_we_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (size_x == '0 || size_y == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // Lengths beyond the memory depth are clamped to the depth.
            nx_d    = (size_x > MAX_X) ? MAX_X : size_x;
            ny_d    = (size_y > MAX_Y) ? MAX_Y : size_y;
            n_d     = '0;
            busy_d  = 1'b1;
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        acc_d    = '0;
        k_d      = kmin_w;
        kmax_d   = kmax_w;
        x_addr_d = ADDRW_X'(kmin_w);
        y_addr_d = ADDRW_Y'(n_q - kmin_w);
        state_d  = S_READ;
      end
      S_READ: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_sum_w;
        if (k_q == kmax_q) begin
          z_we_d   = 1'b1;
          z_addr_d = ADDRW_Z'(n_q);
          z_data_d = res_w;
          state_d  = S_WRITE;
        end else begin
          k_d      = k_q + CW'(1);
          x_addr_d = ADDRW_X'(k_q + CW'(1));
          y_addr_d = ADDRW_Y'(n_q - k_q - CW'(1));
          state_d  = S_READ;
        end
      end
      S_WRITE: begin
        if (n_q == nlast_w) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + CW'(1);
          state_d = S_INIT;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      nx_q     <= '0;
      ny_q     <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      acc_q    <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      z_addr_q <= '0;
      z_data_q <= '0;
      z_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (en_s) begin
      state_q  <= state_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      acc_q    <= acc_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      z_addr_q <= z_addr_d;
      z_data_q <= z_data_d;
      z_we_q   <= z_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem.x_addr = x_addr_q;
  assign mem.y_addr = y_addr_q;
  assign mem.z_addr = z_addr_q;
  assign mem.z_data = z_data_q;
  assign mem.z_we   = z_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_convolution_core.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_convolution_core                                             |
// | Purpose  : Self-checking bench for convolution_core. Models the X/Y        |
// |            synchronous-read memories, logs Z writes and done pulses, and   |
// |            compares them with a direct double-sum convolution model.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_convolution_core;
  localparam int DW = 32;
  localparam int AX = 5;
  localparam int AY = 5;
  localparam int AZ = 6;
  localparam int DX = 1 << AX;
  localparam int DY = 1 << AY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_s = 1'b1;
  logic          start = 1'b0;
  logic [AX:0]   size_x = '0;
  logic [AY:0]   size_y = '0;
  logic          busy;
  logic          done;

  convolution_core_if #(.DATAWIDTH(DW), .ADDRW_X(AX), .ADDRW_Y(AY), .ADDRW_Z(AZ)) mem_if ();

  convolution_core #(.DATAWIDTH(DW), .ADDRW_X(AX), .ADDRW_Y(AY), .ADDRW_Z(AZ)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_s   (en_s),
    .start  (start),
    .size_x (size_x),
    .size_y (size_y),
    .busy   (busy),
    .done   (done),
    .mem    (mem_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] x_mem [DX];
  logic [DW-1:0] y_mem [DY];

  always @(posedge clk) begin
    mem_if.x_data <= x_mem[mem_if.x_addr];
    mem_if.y_data <= y_mem[mem_if.y_addr];
  end

  // Observation log, sampled on the falling edge. tnow indexes cycles.
  int            tnow = 0;
  int            wcnt = 0;
  int            dcnt = 0;
  int            bcnt = 0;
  int            done_t = -1;
  int            wr_addr [4096];
  logic [DW-1:0] wr_data [4096];

  always @(negedge clk) begin
    tnow = tnow + 1;
    if (mem_if.z_we === 1'b1) begin
      wr_addr[wcnt] = int'(mem_if.z_addr);
      wr_data[wcnt] = mem_if.z_data;
      wcnt = wcnt + 1;
    end
    if (done === 1'b1) begin
      dcnt   = dcnt + 1;
      done_t = tnow;
    end
    if (busy === 1'b1) bcnt = bcnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: z[n] = sum over all valid (k, n-k) pairs, 64-bit wrapping.
  function automatic logic [DW-1:0] ref_z(input int nx, input int ny, input int n);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < nx; k++) begin
      if (n - k >= 0 && n - k < ny) acc = acc + 64'(x_mem[k]) * 64'(y_mem[n - k]);
    end
`ifdef CONV_SATURATE_EN
    if (acc[63:32] != 32'd0) return '1;
`endif
    return acc[DW-1:0];
  endfunction

  function automatic int pairs(input int nx, input int ny, input int n);
    int c;
    c = 0;
    for (int k = 0; k < nx; k++) if (n - k >= 0 && n - k < ny) c++;
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode 0: plain, 1: extra start mid-run, 2: en_s low 10 cycles, 3: rst mid-run
  task automatic run(input string tag, input int sx, input int sy, input int mode);
    int nx, ny, nz, w0, d0, b0, t0, exp_t, guard;
    nx = (sx > DX) ? DX : sx;
    ny = (sy > DY) ? DY : sy;
    nz = (nx == 0 || ny == 0) ? 0 : nx + ny - 1;
    exp_t = 1;
    for (int n = 0; n < nz; n++) exp_t += 2 + 2 * pairs(nx, ny, n);
    if (mode == 2) exp_t += 10;
    w0 = wcnt; d0 = dcnt; b0 = bcnt;

    tick();
    t0     = tnow;
    start  = 1'b1;
    size_x = (AX+1)'(sx);
    size_y = (AY+1)'(sy);
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), (nz != 0) ? 64'd1 : 64'd0);

    guard = 0;
    while (dcnt == d0 && guard < 3000) begin
      start = (mode == 1 && tnow == t0 + 5);
      if (mode == 1 && tnow == t0 + 5) size_x = 1;
      en_s = !(mode == 2 && tnow >= t0 + 6 && tnow < t0 + 16);
      rst  = (mode == 3 && tnow == t0 + 7);
      if (mode == 3 && tnow == t0 + 8) check({tag, "_busy_after_rst"}, 64'(busy), 64'd0);
      if (mode == 3 && tnow == t0 + 40) break;
      tick();
      guard++;
    end
    start = 1'b0;
    en_s  = 1'b1;
    rst   = 1'b0;

    if (mode == 3) begin
      check({tag, "_no_done"}, 64'(dcnt - d0), 64'd0);
      check({tag, "_writes_before_rst"}, 64'(wcnt - w0), 64'd1);
      check({tag, "_z_we_low"}, 64'(mem_if.z_we), 64'd0);
    end else begin
      check({tag, "_done_time"}, 64'(done_t - t0), 64'(exp_t));
      repeat (3) tick();
      check({tag, "_done_pulses"}, 64'(dcnt - d0), 64'd1);
      check({tag, "_busy_low"}, 64'(busy), 64'd0);
      check({tag, "_nwrites"}, 64'(wcnt - w0), 64'(nz));
      for (int i = 0; i < nz && w0 + i < wcnt; i++) begin
        check({tag, "_zaddr"}, 64'(wr_addr[w0 + i]), 64'(i));
        check({tag, "_zdata"}, 64'(wr_data[w0 + i]), 64'(ref_z(nx, ny, i)));
      end
      if (nz == 0) check({tag, "_busy_never"}, 64'(bcnt - b0), 64'd0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DX; i++) x_mem[i] = $urandom;
    for (int i = 0; i < DY; i++) y_mem[i] = $urandom;
  endtask

  task automatic load_basic();
    fill_random();
    x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
    y_mem[0] = 1; y_mem[1] = 1;
  endtask

  logic [DW-1:0] kat [4];
  int            wb;

  initial begin
    kat[0] = 1; kat[1] = 3; kat[2] = 5; kat[3] = 3;
    fill_random();

    repeat (3) tick();
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_done",   64'(done),          64'd0);
    check("rst_z_we",   64'(mem_if.z_we),   64'd0);
    check("rst_x_addr", 64'(mem_if.x_addr), 64'd0);
    check("rst_y_addr", 64'(mem_if.y_addr), 64'd0);
    check("rst_z_addr", 64'(mem_if.z_addr), 64'd0);
    check("rst_z_data", 64'(mem_if.z_data), 64'd0);
    rst = 1'b0;
    tick();

    load_basic();
    wb = wcnt;
    run("basic", 3, 2, 0);
    for (int i = 0; i < 4; i++) check("basic_kat", 64'(wr_data[wb + i]), 64'(kat[i]));

    fill_random();
    y_mem[0] = 1;
    wb = wcnt;
    run("unit", 8, 1, 0);
    for (int i = 0; i < 8; i++) check("unit_copy", 64'(wr_data[wb + i]), 64'(x_mem[i]));

    x_mem[0] = 32'hFFFF_FFFF;
    y_mem[0] = 32'hFFFF_FFFF;
    wb = wcnt;
    run("ovf", 1, 1, 0);
`ifdef CONV_SATURATE_EN
    check("ovf_kat", 64'(wr_data[wb]), 64'hFFFF_FFFF);
`else
    check("ovf_kat", 64'(wr_data[wb]), 64'h0000_0001);
`endif

    run("zero", 0, 5, 0);

    load_basic();
    wb = wcnt;
    run("restart", 3, 2, 1);
    for (int i = 0; i < 4; i++) check("restart_kat", 64'(wr_data[wb + i]), 64'(kat[i]));

    load_basic();
    wb = wcnt;
    run("ens", 3, 2, 2);
    for (int i = 0; i < 4; i++) check("ens_kat", 64'(wr_data[wb + i]), 64'(kat[i]));

    load_basic();
    run("rstmid", 3, 2, 3);
    run("after_rst", 3, 2, 0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run("rand", int'($urandom_range(1, DX)), int'($urandom_range(1, DY)), 0);
    end

    fill_random();
    run("clamp", 40, 3, 0);
    fill_random();
    run("full", DX, DY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
